// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter for the single-port SPI RAM command interface, locking the grant per transaction.
// Optional read-response timeout is built when ARB_TIMEOUT_EN is defined.
module spi_ram_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rvalid,
  input  logic [DATA_W+1:0] req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rvalid,
  output logic [DATA_W+1:0] ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic              rd_timeout
);

  localparam int unsigned CMD_W = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic owner, owner_nxt;
  logic last_grant, last_grant_nxt;

  logic [CMD_W-1:0]  own_data;
  logic              own_valid;
  logic [1:0]        own_cmd;
  logic              accept;
  logic              rsp_fire;
  logic              to_fire;
  logic              rsp_done;
  logic [DATA_W-1:0] rsp_data;

  // Owner-side request mux and transaction events
  always_comb begin
    own_data  = owner ? req1_data : req0_data;
    own_valid = owner ? req1_valid : req0_valid;
    own_cmd   = own_data[CMD_W-1:CMD_W-2];
    accept    = (state == OWN) && own_valid;
    rsp_fire  = (state == WAIT_RD) && ram_tx_valid;
    rsp_done  = rsp_fire || to_fire;
    rsp_data  = rsp_fire ? ram_dout : '0;
  end

  // Readies follow the grant directly so the owner can stream a word per cycle
  always_comb begin
    req0_ready = (state == OWN) && !owner;
    req1_ready = (state == OWN) && owner;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside WAIT_RD, so it is cleared on every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != WAIT_RD) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // A response in the final cycle takes priority over the timeout
  assign to_fire = (state == WAIT_RD) && !ram_tx_valid &&
                   (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt      = OWN;
          owner_nxt      = (req0_valid && req1_valid) ? !last_grant : req1_valid;
          last_grant_nxt = owner_nxt;
        end
      end
      OWN: begin
        if (accept) begin
          if (own_cmd == 2'b01) begin
            state_nxt = IDLE;
          end else if (own_cmd == 2'b11) begin
            state_nxt = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (rsp_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered RAM command path and read-data return
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      req0_rdata   <= '0;
      req0_rvalid  <= 1'b0;
      req1_rdata   <= '0;
      req1_rvalid  <= 1'b0;
      rd_timeout   <= 1'b0;
    end else begin
      ram_rx_valid <= accept;
      if (accept) begin
        ram_din <= own_data;
      end
      req0_rvalid <= rsp_done && !owner;
      req1_rvalid <= rsp_done && owner;
      if (rsp_done && !owner) begin
        req0_rdata <= rsp_data;
      end
      if (rsp_done && owner) begin
        req1_rdata <= rsp_data;
      end
      rd_timeout <= to_fire;
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the grant/lock/response rules.
module tb_spi_ram_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = DW + 2;
  localparam int unsigned TO = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [CW-1:0] req0_data, req1_data;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          req0_rvalid, req1_rvalid;
  logic [CW-1:0] ram_din;
  logic          ram_rx_valid;
  logic [DW-1:0] ram_dout;
  logic          ram_tx_valid;
  logic          rd_timeout;

  spi_ram_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .rd_timeout(rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the RAM (-1 = nobody), whether a read response is awaited, last winner
  int            holder;
  bit            awaiting;
  int            prev;
  int            waited;
  logic [CW-1:0] e_din;
  bit            e_rx;
  logic [DW-1:0] e_rdata[2];
  bit            e_rv[2];
  bit            e_to;
  bit            acc[2];

  task automatic model_reset();
    holder = -1; awaiting = 0; prev = 1; waited = 0;
    e_din = '0; e_rx = 0; e_to = 0;
    e_rdata[0] = '0; e_rdata[1] = '0; e_rv[0] = 0; e_rv[1] = 0;
  endtask

  task automatic model_step();
    bit            v[2];
    logic [CW-1:0] d[2];
    v[0] = req0_valid; v[1] = req1_valid;
    d[0] = req0_data;  d[1] = req1_data;
    acc[0] = 0; acc[1] = 0;
    if (rst) begin
      model_reset();
      return;
    end
    acc[0] = v[0] && holder == 0 && !awaiting;
    acc[1] = v[1] && holder == 1 && !awaiting;
    e_rx = 0; e_rv[0] = 0; e_rv[1] = 0; e_to = 0;
    if (holder < 0) begin
      if (v[0] || v[1]) begin
        holder = (v[0] && v[1]) ? 1 - prev : (v[1] ? 1 : 0);
        prev   = holder;
      end
    end else if (!awaiting) begin
      if (v[holder]) begin
        e_rx  = 1;
        e_din = d[holder];
        if (d[holder][CW-1:CW-2] == 2'b01) holder = -1;
        else if (d[holder][CW-1:CW-2] == 2'b11) begin
          awaiting = 1;
          waited   = 0;
        end
      end
    end else if (ram_tx_valid) begin
      e_rdata[holder] = ram_dout;
      e_rv[holder]    = 1;
      holder = -1; awaiting = 0;
    end else begin
      waited++;
      if (TO_EN && waited == int'(TO)) begin
        e_rdata[holder] = '0;
        e_rv[holder]    = 1;
        e_to            = 1;
        holder = -1; awaiting = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ready0", req0_ready, holder == 0 && !awaiting);
    chk("ready1", req1_ready, holder == 1 && !awaiting);
    chk("ram_rx_valid", ram_rx_valid, e_rx);
    chk("ram_din", ram_din, e_din);
    chk("rvalid0", req0_rvalid, e_rv[0]);
    chk("rvalid1", req1_rvalid, e_rv[1]);
    chk("rdata0", req0_rdata, e_rdata[0]);
    chk("rdata1", req1_rdata, e_rdata[1]);
    chk("rd_timeout", rd_timeout, e_to);
  endtask

  // RAM environment
  logic [DW-1:0] mem[256];
  logic [DW-1:0] raddr;
  int            resp_cnt    = -1;
  int            fixed_delay = -1;
  bit            mute = 0;
  bit            spur = 0;

  task automatic ram_env();
    ram_tx_valid = 1'b0;
    if (resp_cnt == 0) begin
      ram_tx_valid = 1'b1;
      ram_dout     = mem[raddr];
      resp_cnt     = -1;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
    end else if (spur && $urandom_range(0, 15) == 0) begin
      ram_tx_valid = 1'b1;
      ram_dout     = DW'($urandom);
    end
    if (ram_rx_valid) begin
      case (ram_din[CW-1:CW-2])
        2'b00, 2'b10: raddr = ram_din[DW-1:0];
        2'b01:        mem[raddr] = ram_din[DW-1:0];
        default:      if (!mute) resp_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      endcase
    end
  endtask

  // Random requesters: each replays a command pair, holding a word until it is accepted
  bit            rand_mode = 0;
  bit            wr_only   = 0;
  bit            rand_rst  = 0;
  int            pval      = 50;
  int            pos[2];
  logic [CW-1:0] words[2][2];

  task automatic new_txn(input int i);
    logic [DW-1:0] a, b;
    a = DW'($urandom);
    b = DW'($urandom);
    if (wr_only || $urandom_range(0, 1) == 0) begin
      words[i][0] = {2'b00, a}; words[i][1] = {2'b01, b};
    end else begin
      words[i][0] = {2'b10, a}; words[i][1] = {2'b11, b};
    end
    pos[i] = 0;
  endtask

  task automatic drive_random();
    bit v[2];
    v[0] = req0_valid; v[1] = req1_valid;
    rst = rand_rst && ($urandom_range(0, 199) == 0);
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        v[i] = 0;
        pos[i]++;
        if (pos[i] == 2) new_txn(i);
      end
      if (rst) begin
        v[i] = 0;
        new_txn(i);
      end
      if (!v[i] && !rst && $urandom_range(0, 99) < pval) v[i] = 1;
    end
    req0_valid = v[0];
    req1_valid = v[1];
    req0_data  = v[0] ? words[0][pos[0]] : CW'($urandom);
    req1_data  = v[1] ? words[1][pos[1]] : CW'($urandom);
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    check_outputs();
    ram_env();
    if (rand_mode) drive_random();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int k;
  int grants[$];
  bit p0, p1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    model_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    ram_tx_valid = 0; ram_dout = '0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_rx_valid", ram_rx_valid, 0);
    chk("reset_din", ram_din, 0);
    chk("reset_rvalid0", req0_rvalid, 0);
    chk("reset_ready0", req0_ready, 0);

    // Write pair from requester 0
    req0_valid = 1; req0_data = 10'h055;
    cycle();
    chk("wr_ready0", req0_ready, 1);
    chk("wr_ready1", req1_ready, 0);
    cycle();
    chk("wr_rx_addr", ram_rx_valid, 1);
    chk("wr_din_addr", ram_din, 10'h055);
    req0_data = 10'h1A3;
    cycle();
    chk("wr_din_data", ram_din, 10'h1A3);
    chk("wr_end_ready0", req0_ready, 0);
    req0_valid = 0;
    cycle();
    chk("wr_rx_low", ram_rx_valid, 0);

    // Read pair from requester 1, RAM answers two cycles after the read-data command
    fixed_delay = 1;
    req1_valid = 1; req1_data = 10'h255;
    cycle();
    chk("rd_ready1", req1_ready, 1);
    cycle();
    chk("rd_din_addr", ram_din, 10'h255);
    req1_data = 10'h300;
    cycle();
    chk("rd_din_cmd", ram_din, 10'h300);
    req1_valid = 0;
    for (k = 1; k <= 10; k++) begin
      cycle();
      if (req1_rvalid) break;
    end
    chk("rd_latency", k, 3);
    chk("rd_rdata1", req1_rdata, 8'hA3);
    chk("rd_rvalid0", req0_rvalid, 0);
    cycle();
    chk("rd_rvalid_pulse", req1_rvalid, 0);

    // Tie from reset then round-robin over write pairs
    do_reset();
    rand_mode = 1; wr_only = 1; pval = 100; rand_rst = 0; spur = 0;
    new_txn(0); new_txn(1);
    acc[0] = 0; acc[1] = 0;
    drive_random();
    p0 = 0; p1 = 0;
    for (int c = 0; c < 80 && grants.size() < 4; c++) begin
      cycle();
      if (req0_ready && !p0) grants.push_back(0);
      if (req1_ready && !p1) grants.push_back(1);
      p0 = req0_ready; p1 = req1_ready;
    end
    chk("rr_count", grants.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_grant", grants[i], i % 2);
    rand_mode = 0; wr_only = 0;
    req0_valid = 0; req1_valid = 0;
    do_reset();

    // Lock: requester 0 idles mid-read while requester 1 waits
    req0_valid = 1; req0_data = 10'h210;
    cycle();
    cycle();
    req0_valid = 0;
    req1_valid = 1; req1_data = 10'h0AA;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("lock_ready1", req1_ready, 0);
      chk("lock_ready0", req0_ready, 1);
    end
    req0_valid = 1; req0_data = 10'h300;
    cycle();
    req0_valid = 0;
    for (k = 1; k <= 10; k++) begin
      cycle();
      chk("lock_ready1_wait", req1_ready, 0);
      if (req0_rvalid) break;
    end
    chk("lock_rsp_seen", req0_rvalid, 1);
    cycle();
    chk("lock_ready1_after", req1_ready, 1);
    req1_valid = 0;
    do_reset();

    // Reset while waiting for read data; the late response must be ignored
    fixed_delay = 4;
    req0_valid = 1; req0_data = 10'h255;
    cycle();
    cycle();
    req0_data = 10'h300;
    cycle();
    req0_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    chk("rstrd_rx", ram_rx_valid, 0);
    chk("rstrd_din", ram_din, 0);
    chk("rstrd_rdata0", req0_rdata, 0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rstrd_rvalid0", req0_rvalid, 0);
      chk("rstrd_rvalid1", req1_rvalid, 0);
    end

`ifdef ARB_TIMEOUT_EN
    // Read with no RAM response
    do_reset();
    mute = 1;
    req0_valid = 1; req0_data = 10'h255;
    cycle();
    cycle();
    req0_data = 10'h300;
    cycle();
    req0_valid = 0;
    for (k = 1; k <= 40; k++) begin
      cycle();
      if (rd_timeout) break;
    end
    chk("to_latency", k, TO);
    chk("to_rvalid0", req0_rvalid, 1);
    chk("to_rdata0", req0_rdata, 0);
    cycle();
    chk("to_pulse", rd_timeout, 0);
    mute = 0;
`endif

    // Randomized traffic with spurious RAM strobes and occasional resets
    do_reset();
    fixed_delay = -1;
    rand_mode = 1; wr_only = 0; pval = 40; spur = 1; rand_rst = 1;
    new_txn(0); new_txn(1);
    acc[0] = 0; acc[1] = 0;
    drive_random();
    repeat (3000) cycle();
    rand_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
